// File: rtl/pc_predict_unit_pkg.sv
// pc_predict_unit_pkg: shared types for the fetch-stage predictor
package pc_predict_unit_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;
endpackage

// File: rtl/pc_predict_unit_if.sv
// pc_predict_unit_if: fetch control and execute-stage resolution bundle
interface pc_predict_unit_if #(parameter int WORD_W = 32);
  logic ihit, stall, redirect, upd_valid, upd_taken, upd_is_jump, pred_taken;
  logic [WORD_W-1:0] redirect_pc, upd_pc, upd_target, pcaddr, nxt_pc, pred_target;
  modport master (
    output ihit, stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    input pcaddr, nxt_pc, pred_taken, pred_target
  );
  modport slave (
    input ihit, stall, redirect, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
    output pcaddr, nxt_pc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_predict_unit_btb.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters
module branch_target_buffer import pc_predict_unit_pkg::*; #(
  parameter int BTB_ENTRIES = 16,
  parameter int WORD_W = 32,
  parameter int CNT_W = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic [WORD_W-3:0] pc,
  output logic hit,
  output logic taken,
  output logic [WORD_W-1:0] target,
  input  logic upd_valid,
  input  logic upd_taken,
  input  logic upd_is_jump,
  input  logic [WORD_W-3:0] upd_pc,
  input  logic [WORD_W-1:0] upd_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_W - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WT) << (CNT_W - 2);
  typedef struct packed {
    logic valid;
    logic jump;
    logic [TAG_W-1:0] tag;
    logic [WORD_W-1:0] target;
    logic [CNT_W-1:0] cnt;
  } btb_entry_t;
  btb_entry_t mem [BTB_ENTRIES];
  btb_entry_t rd, cur, nxt;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic uhit;
  // pc and upd_pc are word addresses, so the index sits in the low bits
  assign rd = mem[pc[IDX_W-1:0]];
  assign hit = rd.valid && rd.tag == pc[WORD_W-3:IDX_W];
  assign taken = rd.jump || rd.cnt[CNT_W-1];
  assign target = rd.target;
  assign uidx = upd_pc[IDX_W-1:0];
  assign utag = upd_pc[WORD_W-3:IDX_W];
  assign cur = mem[uidx];
  assign uhit = cur.valid && cur.tag == utag;
  always_comb
    nxt = !uhit ? (upd_taken ? btb_entry_t'{valid: 1'b1, jump: upd_is_jump, tag: utag, target: upd_target, cnt: CNT_INIT} : cur)
        : upd_taken ? btb_entry_t'{valid: 1'b1, jump: upd_is_jump, tag: cur.tag, target: upd_target,
                                   cnt: &cur.cnt ? cur.cnt : cur.cnt + CNT_W'(1)}
        : btb_entry_t'{valid: 1'b1, jump: cur.jump, tag: cur.tag, target: cur.target,
                       cnt: |cur.cnt ? cur.cnt - CNT_W'(1) : cur.cnt};
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) for (int i = 0; i < BTB_ENTRIES; i++) mem[i] <= '0;
    else if (upd_valid) mem[uidx] <= nxt;
endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with BTB-driven next-address prediction
module pc_predict_unit import pc_predict_unit_pkg::*; #(
  parameter int WORD_W = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 2
) (
  input logic CLK,
  input logic nRST,
  pc_predict_unit_if.slave pcif
);
  logic hit, taken;
  logic [WORD_W-1:0] target, pcaddr;
  branch_target_buffer #(.BTB_ENTRIES(BTB_ENTRIES), .WORD_W(WORD_W), .CNT_W(CNT_W)) btb (
    .CLK(CLK),
    .nRST(nRST),
    .pc(pcaddr[WORD_W-1:2]),
    .hit(hit),
    .taken(taken),
    .target(target),
    .upd_valid(pcif.upd_valid),
    .upd_taken(pcif.upd_taken),
    .upd_is_jump(pcif.upd_is_jump),
    .upd_pc(pcif.upd_pc[WORD_W-1:2]),
    .upd_target(pcif.upd_target)
  );
  assign pcif.pcaddr = pcaddr;
  assign pcif.nxt_pc = pcaddr + WORD_W'(4);
  assign pcif.pred_taken = hit && taken;
  assign pcif.pred_target = pcif.pred_taken ? target & ~WORD_W'(3) : pcif.nxt_pc;
  // redirect outranks stall so a mispredict is never lost behind a hazard freeze
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) pcaddr <= RESET_PC;
    else if (pcif.redirect) pcaddr <= pcif.redirect_pc & ~WORD_W'(3);
    else if (!pcif.stall && pcif.ihit) pcaddr <= pcif.pred_target;
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed scoreboard bench for the predicting fetch PC
module tb_pc_predict_unit;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nxt;
    logic pt;
    logic [31:0] tgt;
  } obs_t;
  typedef struct {
    string tag;
    obs_t v;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  pc_predict_unit_if #(.WORD_W(32)) bus ();
  pc_predict_unit #(.WORD_W(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(2)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .pcif(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ihit = 0;
    bus.stall = 0;
    bus.redirect = 0;
    bus.redirect_pc = '0;
    bus.upd_valid = 0;
    bus.upd_pc = '0;
    bus.upd_taken = 0;
    bus.upd_target = '0;
    bus.upd_is_jump = 0;
  endtask

  task automatic want(string tag, logic [31:0] pc, logic pt, logic [31:0] tgt);
    exp_t e;
    e.tag = tag;
    e.v = '{pc, pc + 32'd4, pt, tgt};
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    obs_t o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = '{bus.pcaddr, bus.nxt_pc, bus.pred_taken, bus.pred_target};
      tests++;
      assert (o === e.v) else begin
        fails++;
        $error("FAIL %s: pcaddr/nxt_pc/pred_taken/pred_target got %h/%h/%b/%h want %h/%h/%b/%h",
               e.tag, o.pc, o.nxt, o.pt, o.tgt, e.v.pc, e.v.nxt, e.v.pt, e.v.tgt);
      end
    end
  endtask

  task automatic step(string tag, logic [31:0] pc, logic pt, logic [31:0] tgt);
    want(tag, pc, pt, tgt);
    tick();
    check();
    idle();
  endtask

  task automatic fetch(string tag, logic [31:0] pc, logic pt, logic [31:0] tgt);
    bus.ihit = 1;
    step(tag, pc, pt, tgt);
  endtask

  task automatic redir(logic [31:0] a);
    bus.redirect = 1;
    bus.redirect_pc = a;
  endtask

  task automatic upd(logic [31:0] a, logic tk, logic [31:0] tg, logic j);
    bus.upd_valid = 1;
    bus.upd_pc = a;
    bus.upd_taken = tk;
    bus.upd_target = tg;
    bus.upd_is_jump = j;
  endtask

  initial begin
    idle();
    #1;
    want("reset_hold", 32'h0, 0, 32'h4);
    check();
    tick();
    nRST = 1;
    step("reset_release", 32'h0, 0, 32'h4);
    fetch("seq_4", 32'h4, 0, 32'h8);
    fetch("seq_8", 32'h8, 0, 32'hC);
    fetch("seq_c", 32'hC, 0, 32'h10);
    bus.ihit = 1;
    nRST = 0;
    want("async_reset", 32'h0, 0, 32'h4);
    #1;
    check();
    bus.ihit = 0;
    #1;
    nRST = 1;
    step("after_reset", 32'h0, 0, 32'h4);
    // allocate 0x10 -> 0x40 and fetch through it
    upd(32'h10, 1, 32'h40, 0);
    step("alloc_10", 32'h0, 0, 32'h4);
    fetch("f_4", 32'h4, 0, 32'h8);
    fetch("f_8", 32'h8, 0, 32'hC);
    fetch("f_c", 32'hC, 0, 32'h10);
    fetch("f_10_hit", 32'h10, 1, 32'h40);
    fetch("f_40", 32'h40, 0, 32'h44);
    // not-taken training with simultaneous redirect, then hysteresis
    redir(32'h10);
    upd(32'h10, 0, 32'h0, 0);
    step("nt1_wnt", 32'h10, 0, 32'h14);
    upd(32'h10, 0, 32'h0, 0);
    step("nt2_snt", 32'h10, 0, 32'h14);
    upd(32'h10, 0, 32'h0, 0);
    step("nt3_sat_snt", 32'h10, 0, 32'h14);
    upd(32'h10, 1, 32'h40, 0);
    step("hyst_wnt", 32'h10, 0, 32'h14);
    upd(32'h10, 1, 32'h40, 0);
    step("back_wt", 32'h10, 1, 32'h40);
    // redirect priority and stall
    redir(32'h203);
    bus.stall = 1;
    bus.ihit = 1;
    step("redir_over_stall", 32'h200, 0, 32'h204);
    bus.stall = 1;
    bus.ihit = 1;
    step("stall_hold", 32'h200, 0, 32'h204);
    fetch("resume", 32'h204, 0, 32'h208);
    // aliasing replacement at index 4
    upd(32'h50, 1, 32'h90, 0);
    redir(32'h10);
    step("alias_miss", 32'h10, 0, 32'h14);
    redir(32'h50);
    step("alias_hit", 32'h50, 1, 32'h90);
    upd(32'h50, 1, 32'h90, 0);
    step("up_st", 32'h50, 1, 32'h90);
    upd(32'h50, 1, 32'h90, 0);
    step("up_sat1", 32'h50, 1, 32'h90);
    upd(32'h50, 1, 32'h90, 0);
    step("up_sat2", 32'h50, 1, 32'h90);
    upd(32'h50, 0, 32'h0, 0);
    step("down_wt", 32'h50, 1, 32'h90);
    upd(32'h50, 0, 32'h0, 0);
    step("down_wnt", 32'h50, 0, 32'h54);
    // jump entry stays taken after its counter bottoms out
    upd(32'h80, 1, 32'h100, 1);
    step("jmp_alloc", 32'h50, 0, 32'h54);
    for (int i = 0; i < 3; i++) begin
      upd(32'h80, 0, 32'h0, 0);
      step("jmp_nt", 32'h50, 0, 32'h54);
    end
    redir(32'h80);
    step("jmp_snt", 32'h80, 1, 32'h100);
    // same-cycle update and lookup: no bypass
    redir(32'h24);
    step("to_24", 32'h24, 0, 32'h28);
    upd(32'h24, 1, 32'h300, 0);
    want("same_old", 32'h24, 0, 32'h28);
    #1;
    check();
    step("same_new", 32'h24, 1, 32'h300);
    redir(32'h2C);
    step("to_2c", 32'h2C, 0, 32'h30);
    upd(32'h2C, 1, 32'h310, 0);
    bus.ihit = 1;
    step("same_ihit_old", 32'h30, 0, 32'h34);
    redir(32'h2C);
    step("same_ihit_new", 32'h2C, 1, 32'h310);
    // address wrap
    redir(32'hFFFF_FFFC);
    step("wrap_top", 32'hFFFF_FFFC, 0, 32'h0);
    fetch("wrap_zero", 32'h0, 0, 32'h4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
